// File: rtl/aes_ark_pkg.sv
// rtl/aes_ark_pkg.sv - shared types, round-count constants and index helpers for the AddRoundKey stage
package aes_ark_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_OUT  = 2'd2
  } ark_state_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  // Encryption walks keys 0..nr, decryption walks nr..0.
  function automatic int start_idx(input logic dec, input int nr);
    return dec ? nr : 0;
  endfunction

  function automatic int last_idx(input logic dec, input int nr);
    return dec ? 0 : nr;
  endfunction

endpackage

// File: rtl/mod_ark_xor.sv
// rtl/mod_ark_xor.sv - NB-byte lane array XORing a round key into the state word
module mod_ark_xor #(
  parameter int NB = 16
) (
  input  logic [NB*8-1:0] state,
  input  logic [NB*8-1:0] key,
  output logic [NB*8-1:0] result
);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign result[8*i +: 8] = state[8*i +: 8] ^ key[8*i +: 8];
  end

endmodule

// File: rtl/mod_enc_ark_stage.sv
// rtl/mod_enc_ark_stage.sv - handshaked AddRoundKey stage with internal round-index tracking
module mod_enc_ark_stage
  import aes_ark_pkg::*;
#(
  parameter int NB = 16,
  parameter int NR = NR_256,
  parameter int RW = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NB*8-1:0] in_data,
  input  logic            in_first,
  input  logic            in_dec,
  output logic            key_req,
  output logic [RW-1:0]   key_idx,
  input  logic            key_vld,
  input  logic [NB*8-1:0] key_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NB*8-1:0] out_data,
  output logic [RW-1:0]   out_round,
  output logic            out_final,
  output logic            seq_err
);

  ark_state_e state, state_nxt;

  logic [NB*8-1:0] data_q;
  logic [NB*8-1:0] xor_w;
  logic [RW-1:0]   idx_q;
  logic [RW-1:0]   cnt_q;
  logic [RW-1:0]   idx_sel;
  logic            dir_q;
  logic            dir_sel;
  logic            done_q;
  logic            seq_hit;
  logic            accept;
  logic            key_hs;
  logic            out_hs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    key_req   = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_KEY;
      end
      ST_KEY: begin
        key_req = 1'b1;
        if (key_vld) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept  = in_ready & in_valid;
  assign key_hs  = key_req & key_vld;
  assign out_hs  = out_valid & out_ready;
  assign key_idx = idx_q;

  // A non-first word after the block's last round restarts at the start index.
  always_comb begin
    idx_sel = cnt_q;
    dir_sel = dir_q;
    seq_hit = 1'b0;
    if (in_first) begin
      dir_sel = in_dec;
      idx_sel = RW'(start_idx(in_dec, NR));
    end else if (done_q) begin
      seq_hit = 1'b1;
      idx_sel = RW'(start_idx(dir_q, NR));
    end
  end

  mod_ark_xor #(.NB(NB)) u_xor (
    .state  (data_q),
    .key    (key_data),
    .result (xor_w)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      seq_err   <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_final <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        idx_q  <= idx_sel;
        dir_q  <= dir_sel;
        done_q <= 1'b0;
        if (in_first)     seq_err <= 1'b0;
        else if (seq_hit) seq_err <= 1'b1;
      end
      if (key_hs) begin
        out_data  <= xor_w;
        out_round <= idx_q;
        out_final <= (idx_q == RW'(last_idx(dir_q, NR)));
      end
      // The counter saturates on the last index; done_q marks the block as exhausted.
      if (out_hs) begin
        if (out_final)  done_q <= 1'b1;
        else if (dir_q) cnt_q  <= out_round - 1'b1;
        else            cnt_q  <= out_round + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_enc_ark_stage.sv
// tb/tb_mod_enc_ark_stage.sv - self-checking bench for mod_enc_ark_stage (NR=14 and NR=10 instances)
module tb_mod_enc_ark_stage;

  localparam int NB = 16;
  localparam int RW = 4;
  localparam int W  = NB * 8;

  logic clk = 1'b0;
  logic resetn;
  logic in_valid, in_first, in_dec, key_vld, out_ready;
  logic [W-1:0] in_data;

  logic          in_ready_w  [2];
  logic          key_req_w   [2];
  logic          out_valid_w [2];
  logic          out_final_w [2];
  logic          seq_err_w   [2];
  logic [RW-1:0] key_idx_w   [2];
  logic [RW-1:0] out_round_w [2];
  logic [W-1:0]  out_data_w  [2];
  logic [W-1:0]  key_data_w  [2];
  logic [W-1:0]  key_tab     [16];

  int checks = 0;
  int errors = 0;

  // Behavioural model: position within the block, direction and the last delivered result.
  int            nr_m   [2];
  int            m_pos  [2];
  logic          m_dir  [2];
  logic          m_seq  [2];
  logic          m_fin  [2];
  logic [RW-1:0] m_idx  [2];
  logic [W-1:0]  m_data [2];
  logic [RW-1:0] sh_round [2];
  logic          sh_fin   [2];
  logic [W-1:0]  sh_data  [2];
  int            phase;
  bit            cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign key_data_w[0] = key_tab[key_idx_w[0]];
  assign key_data_w[1] = key_tab[key_idx_w[1]];

  mod_enc_ark_stage #(.NB(NB), .NR(14), .RW(RW)) u_dut14 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .in_first(in_first), .in_dec(in_dec),
    .key_req(key_req_w[0]), .key_idx(key_idx_w[0]), .key_vld(key_vld), .key_data(key_data_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_round(out_round_w[0]), .out_final(out_final_w[0]), .seq_err(seq_err_w[0])
  );

  mod_enc_ark_stage #(.NB(NB), .NR(10), .RW(RW)) u_dut10 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .in_first(in_first), .in_dec(in_dec),
    .key_req(key_req_w[1]), .key_idx(key_idx_w[1]), .key_vld(key_vld), .key_data(key_data_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_round(out_round_w[1]), .out_final(out_final_w[1]), .seq_err(seq_err_w[1])
  );

  task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d]: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    for (int k = 0; k < 2; k++) begin
      m_pos[k]    = 0;
      m_dir[k]    = 1'b0;
      m_seq[k]    = 1'b0;
      m_fin[k]    = 1'b0;
      m_idx[k]    = '0;
      m_data[k]   = '0;
      sh_round[k] = '0;
      sh_fin[k]   = 1'b0;
      sh_data[k]  = '0;
    end
  endtask

  task automatic model_accept(input logic [W-1:0] d, input logic f, input logic dec);
    for (int k = 0; k < 2; k++) begin
      if (f) begin
        m_dir[k] = dec;
        m_pos[k] = 0;
        m_seq[k] = 1'b0;
      end else if (m_pos[k] > nr_m[k]) begin
        m_seq[k] = 1'b1;
        m_pos[k] = 0;
      end
      m_idx[k]  = RW'(m_dir[k] ? nr_m[k] - m_pos[k] : m_pos[k]);
      m_fin[k]  = (m_pos[k] == nr_m[k]);
      m_data[k] = d ^ key_tab[m_idx[k]];
    end
    phase = 1;
  endtask

  task automatic model_key();
    for (int k = 0; k < 2; k++) begin
      sh_data[k]  = m_data[k];
      sh_round[k] = m_idx[k];
      sh_fin[k]   = m_fin[k];
    end
    phase = 2;
  endtask

  task automatic model_out();
    for (int k = 0; k < 2; k++) m_pos[k] = m_pos[k] + 1;
    phase = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en && resetn) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready",  k, W'(in_ready_w[k]),  W'(phase == 0));
        chk("key_req",   k, W'(key_req_w[k]),   W'(phase == 1));
        chk("out_valid", k, W'(out_valid_w[k]), W'(phase == 2));
        if (phase == 1) chk("key_idx", k, W'(key_idx_w[k]), W'(m_idx[k]));
        chk("out_data",  k, out_data_w[k],      sh_data[k]);
        chk("out_round", k, W'(out_round_w[k]), W'(sh_round[k]));
        chk("out_final", k, W'(out_final_w[k]), W'(sh_fin[k]));
        chk("seq_err",   k, W'(seq_err_w[k]),   W'(m_seq[k]));
      end
    end
  end

  task automatic do_accept(input logic [W-1:0] d, input logic f, input logic dec);
    int n = 0;
    @(negedge clk);
    while (!(in_ready_w[0] && in_ready_w[1]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose within 50 cycles");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_dec   = dec;
    @(posedge clk);
    model_accept(d, f, dec);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_dec   = 1'b0;
  endtask

  task automatic do_key(input int kd, input bit spur_or);
    for (int i = 0; i < kd; i++) begin
      if (spur_or && i == 0) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    key_vld = 1'b1;
    @(posedge clk);
    model_key();
    #1 key_vld = 1'b0;
  endtask

  task automatic do_out(input int od);
    for (int i = 0; i < od; i++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    model_out();
    #1 out_ready = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic f, input logic dec, input int kd, input int od, input bit spur);
    do_accept(d, f, dec);
    do_key(kd, spur);
    do_out(od);
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] d;
    nr_m[0] = 14;
    nr_m[1] = 10;
    for (int i = 0; i < 16; i++) key_tab[i] = rnd128();
    key_tab[10] = 128'h000102030405060708090a0b0c0d0e0f;
    resetn = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_dec = 1'b0;
    in_data = '0; key_vld = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready",  k, W'(in_ready_w[k]),  W'(1'b1));
      chk("rst_key_req",   k, W'(key_req_w[k]),   W'(1'b0));
      chk("rst_key_idx",   k, W'(key_idx_w[k]),   W'(0));
      chk("rst_out_valid", k, W'(out_valid_w[k]), W'(1'b0));
      chk("rst_out_data",  k, out_data_w[k],      '0);
      chk("rst_out_round", k, W'(out_round_w[k]), W'(0));
      chk("rst_out_final", k, W'(out_final_w[k]), W'(1'b0));
      chk("rst_seq_err",   k, W'(seq_err_w[k]),   W'(1'b0));
    end
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Encryption sweep with an immediate key source
    for (int i = 0; i < 15; i++) begin
      d = rnd128();
      do_accept(d, (i == 0), 1'b0);
      chk("enc_key_req_t1", 0, W'(key_req_w[0]), W'(1'b1));
      chk("enc_key_idx",    0, W'(key_idx_w[0]), W'(i));
      do_key(0, 1'b0);
      chk("enc_latency",    0, W'(out_valid_w[0]), W'(1'b1));
      chk("enc_round",      0, W'(out_round_w[0]), W'(i));
      chk("enc_final",      0, W'(out_final_w[0]), W'(i == 14));
      chk("enc_data",       0, out_data_w[0], d ^ key_tab[i]);
      do_out(0);
    end

    // Decryption sweep on the NR=10 instance
    do_accept(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1);
    chk("dec_key_idx", 1, W'(key_idx_w[1]), W'(10));
    do_key(0, 1'b0);
    chk("dec_data",  1, out_data_w[1], 128'h00102030405060708090a0b0c0d0e0f0);
    chk("dec_round", 1, W'(out_round_w[1]), W'(10));
    chk("dec_final", 1, W'(out_final_w[1]), W'(1'b0));
    do_out(0);
    for (int i = 9; i >= 0; i--) begin
      do_accept(rnd128(), 1'b0, 1'b0);
      do_key(0, 1'b0);
      chk("dec_round_dn", 1, W'(out_round_w[1]), W'(i));
      chk("dec_final_dn", 1, W'(out_final_w[1]), W'(i == 0));
      do_out(0);
    end

    // Spurious key_vld while idle, then key stall plus output backpressure
    @(negedge clk);
    key_vld = 1'b1;
    @(posedge clk);
    #1 key_vld = 1'b0;
    send(rnd128(), 1'b0, 1'b0, 5, 4, 1'b1);
    chk("bp_round", 0, W'(out_round_w[0]), W'(3));

    // Sequence error after the final encryption round
    for (int i = 0; i < 15; i++) send(rnd128(), (i == 0), 1'b0, 0, 0, 1'b0);
    do_accept(rnd128(), 1'b0, 1'b0);
    chk("seq_err_set", 0, W'(seq_err_w[0]), W'(1'b1));
    do_key(0, 1'b0);
    chk("seq_round", 0, W'(out_round_w[0]), W'(0));
    do_out(0);
    do_accept(rnd128(), 1'b1, 1'b0);
    chk("seq_err_clr", 0, W'(seq_err_w[0]), W'(1'b0));
    do_key(1, 1'b0);
    do_out(1);

    // Reset while waiting for a key
    do_accept(rnd128(), 1'b1, 1'b1);
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_key_req",   k, W'(key_req_w[k]),   W'(1'b0));
      chk("mid_rst_out_valid", k, W'(out_valid_w[k]), W'(1'b0));
      chk("mid_rst_in_ready",  k, W'(in_ready_w[k]),  W'(1'b1));
      chk("mid_rst_out_data",  k, out_data_w[k],      '0);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    d = rnd128();
    do_accept(d, 1'b0, 1'b0);
    do_key(0, 1'b0);
    chk("post_rst_round", 0, W'(out_round_w[0]), W'(0));
    chk("post_rst_data",  1, out_data_w[1], d ^ key_tab[0]);
    do_out(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
